// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC, latches ROM commands and drives
// bus-register enables for MV/MVI/ADD/SUB/JMP/NOP/HALT. Optional single-step: SEQ_STEP_EN.
module instr_sequencer #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned CMD_W     = 23,
    parameter int unsigned ROM_LAT   = 1,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef SEQ_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [CMD_W-1:0]  rom_q,
    output logic [9:0]        reg_enable_out,
    output logic [9:0]        reg_enable_in,
    output logic              addsub,
    output logic [15:0]       data,
    output logic              busy,
    output logic              halted,
    output logic              instr_done,
    output logic              illegal
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned EN_W  = 10;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_ILL  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [EN_W-1:0] EN_G_OUT   = 10'h100;
    localparam logic [EN_W-1:0] EN_IMM_OUT = 10'h200;
    localparam logic [EN_W-1:0] EN_A_IN    = 10'h100;
    localparam logic [EN_W-1:0] EN_G_IN    = 10'h200;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EX1, S_EX2, S_EX3, S_HALTED, S_STEP_WAIT
    } state_e;

`ifdef SEQ_STEP_EN
    localparam state_e AFTER_EXEC = S_STEP_WAIT;
`else
    localparam state_e AFTER_EXEC = S_FETCH;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CMD_W-1:0]  ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              illegal_q, illegal_d;
    logic [EN_W-1:0]   en_out_q, en_out_d, en_in_q, en_in_d;
    logic              addsub_q, addsub_d, busy_q, busy_d;
    logic              halted_q, halted_d, done_q, done_d;
    logic [2:0]        op_q, op_d, rx_d, ry_d;
    logic              fetch_last;

    function automatic logic [EN_W-1:0] reg_sel(input logic [2:0] idx);
        return EN_W'(1) << idx;
    endfunction

    assign op_q       = ir_q[22:20];
    assign fetch_last = (cnt_q == CNT_W'(ROM_LAT - 1));

    // Sequencing: PC, instruction register, fetch-latency counter, sticky illegal
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        cnt_d     = '0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = ADDR_W'(RESET_VEC);
                    illegal_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (fetch_last) begin
                    ir_d    = rom_q;
                    state_d = S_EX1;
                    if (rom_q[22:20] == OP_ILL) illegal_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EX1: begin
                case (op_q)
                    OP_ADD, OP_SUB: state_d = S_EX2;
                    OP_JMP: begin
                        pc_d    = ir_q[ADDR_W-1:0];
                        state_d = AFTER_EXEC;
                    end
                    OP_HALT: state_d = S_HALTED;
                    default: begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = AFTER_EXEC;
                    end
                endcase
            end
            S_EX2: state_d = S_EX3;
            S_EX3: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = AFTER_EXEC;
            end
`ifdef SEQ_STEP_EN
            S_STEP_WAIT: if (step) state_d = S_FETCH;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it
    always_comb begin
        op_d     = ir_d[22:20];
        rx_d     = ir_d[18:16];
        ry_d     = ir_d[14:12];
        en_out_d = '0;
        en_in_d  = '0;
        addsub_d = 1'b0;
        done_d   = 1'b0;
        busy_d   = (state_d != S_IDLE) && (state_d != S_HALTED);
        halted_d = (state_d == S_HALTED);
        case (state_d)
            S_EX1: begin
                done_d = (op_d != OP_ADD) && (op_d != OP_SUB);
                case (op_d)
                    OP_MV: begin
                        en_out_d = reg_sel(ry_d);
                        en_in_d  = reg_sel(rx_d);
                    end
                    OP_MVI: begin
                        en_out_d = EN_IMM_OUT;
                        en_in_d  = reg_sel(rx_d);
                    end
                    OP_ADD, OP_SUB: begin
                        en_out_d = reg_sel(rx_d);
                        en_in_d  = EN_A_IN;
                    end
                    default: ;
                endcase
            end
            S_EX2: begin
                en_out_d = reg_sel(ry_d);
                en_in_d  = EN_G_IN;
                addsub_d = op_d[0];
            end
            S_EX3: begin
                en_out_d = EN_G_OUT;
                en_in_d  = reg_sel(rx_d);
                addsub_d = op_d[0];
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= ADDR_W'(RESET_VEC);
            ir_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            en_out_q  <= '0;
            en_in_q   <= '0;
            addsub_q  <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            en_out_q  <= en_out_d;
            en_in_q   <= en_in_d;
            addsub_q  <= addsub_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            done_q    <= done_d;
        end
    end

    assign rom_addr       = pc_q;
    assign reg_enable_out = en_out_q;
    assign reg_enable_in  = en_in_q;
    assign addsub         = addsub_q;
    assign data           = ir_q[15:0];
    assign busy           = busy_q;
    assign halted         = halted_q;
    assign instr_done     = done_q;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level model expands each ROM word into
// expected per-cycle outputs; a toy datapath checks register results.
module tb_instr_sequencer;

    localparam int unsigned ROM_LAT = 1;
`ifdef SEQ_STEP_EN
    localparam int W = 1;
`else
    localparam int W = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
`ifdef SEQ_STEP_EN
    logic        step = 1'b1;
`endif
    logic [8:0]  rom_addr;
    logic [22:0] rom_q;
    logic [9:0]  eo, ei;
    logic        addsub, busy, halted, instr_done, illegal;
    logic [15:0] data;

    logic [22:0] rom [512];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;
    assign rom_q = rom[rom_addr];

    instr_sequencer #(.ADDR_W(9), .CMD_W(23), .ROM_LAT(ROM_LAT), .RESET_VEC(0)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef SEQ_STEP_EN
        .step(step),
`endif
        .rom_addr(rom_addr), .rom_q(rom_q),
        .reg_enable_out(eo), .reg_enable_in(ei), .addsub(addsub), .data(data),
        .busy(busy), .halted(halted), .instr_done(instr_done), .illegal(illegal)
    );

    // Toy datapath driven by the enables
    logic [15:0] r [8] = '{default: 16'h0};
    logic [15:0] a_reg = 16'h0, g_reg = 16'h0, bus;
    always_comb begin
        bus = '0;
        for (int k = 0; k < 8; k++) if (eo[k] === 1'b1) bus = bus | r[k];
        if (eo[8] === 1'b1) bus = bus | g_reg;
        if (eo[9] === 1'b1) bus = bus | data;
    end
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) if (ei[k] === 1'b1) r[k] <= bus;
        if (ei[8] === 1'b1) a_reg <= bus;
        if (ei[9] === 1'b1) g_reg <= addsub ? a_reg - bus : a_reg + bus;
    end

    typedef struct packed {
        logic [8:0]  addr;
        logic [9:0]  eo;
        logic [9:0]  ei;
        logic        as;
        logic        busy;
        logic        halted;
        logic        done;
        logic        ill;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    exp_t        cur, act;
    logic [22:0] last_ir = '0;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    function automatic exp_t mk(input logic [8:0] addr, input logic [9:0] eo_v,
                                input logic [9:0] ei_v, input logic as_v, input logic busy_v,
                                input logic halted_v, input logic done_v, input logic ill_v,
                                input logic [15:0] d);
        exp_t e;
        e = '{addr: addr, eo: eo_v, ei: ei_v, as: as_v, busy: busy_v,
              halted: halted_v, done: done_v, ill: ill_v, data: d};
        return e;
    endfunction

    // Instruction-level interpreter: one entry per expected clock cycle
    task automatic model_run(input int max_instr);
        logic [8:0]  pc;
        logic [22:0] w;
        logic [2:0]  op;
        logic [9:0]  sx, sy;
        logic        ill;
        pc  = '0;
        ill = 1'b0;
        for (int n = 0; n < max_instr; n++) begin
            w  = rom[pc];
            op = w[22:20];
            sx = 10'd1 << w[18:16];
            sy = 10'd1 << w[14:12];
            for (int c = 0; c < ROM_LAT; c++)
                q.push_back(mk(pc, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, ill, last_ir[15:0]));
            last_ir = w;
            if (op == 3'b101) ill = 1'b1;
            case (op)
                3'b000: q.push_back(mk(pc, sy, sx, 1'b0, 1'b1, 1'b0, 1'b1, ill, w[15:0]));
                3'b001: q.push_back(mk(pc, 10'h200, sx, 1'b0, 1'b1, 1'b0, 1'b1, ill, w[15:0]));
                3'b010, 3'b011: begin
                    q.push_back(mk(pc, sx, 10'h100, 1'b0, 1'b1, 1'b0, 1'b0, ill, w[15:0]));
                    q.push_back(mk(pc, sy, 10'h200, op[0], 1'b1, 1'b0, 1'b0, ill, w[15:0]));
                    q.push_back(mk(pc, 10'h100, sx, op[0], 1'b1, 1'b0, 1'b1, ill, w[15:0]));
                end
                default: q.push_back(mk(pc, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, ill, w[15:0]));
            endcase
            if (op == 3'b111) begin
                q.push_back(mk(pc, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, ill, w[15:0]));
                return;
            end
            pc = (op == 3'b100) ? w[8:0] : pc + 9'd1;
`ifdef SEQ_STEP_EN
            q.push_back(mk(pc, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, ill, w[15:0]));
`endif
        end
    endtask

    // Per-cycle comparison against the model while it has entries
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            act = '{addr: rom_addr, eo: eo, ei: ei, as: addsub, busy: busy,
                    halted: halted, done: instr_done, ill: illegal, data: data};
            chk($sformatf("cycle@%0t", $time), 64'(act), 64'(cur));
        end
        if (instr_done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        q.delete();
        rst     = 1'b0;
        last_ir = '0;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic launch(input int max_instr);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (max_instr > 0) model_run(max_instr);
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && q.size() > 0; i++) @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 23'h700000;
        #2 rst = 1'b0;
        #1 chk("reset_outputs",
               64'({rom_addr, eo, ei, addsub, data, busy, halted, instr_done, illegal}), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // T1: MVI R1,5 ; HALT, with starts that must be ignored
        rom[0] = 23'h110005; rom[1] = 23'h700000;
        done_cnt = 0;
        launch(2);
        tick(1);
        chk("t1_c1_addr_busy", 64'({rom_addr, busy}), 64'({9'd0, 1'b1}));
        tick(1);
        chk("t1_c2_enables", 64'({eo, ei, data}), 64'({10'h200, 10'h002, 16'h0005}));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        tick(2 + W);
        chk("t1_halt_done", 64'(instr_done), 64'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        tick(1);
        chk("t1_halted", 64'({halted, busy}), 64'({1'b1, 1'b0}));
        drain();
        chk("t1_r1", 64'(r[1]), 64'h5);
        chk("t1_done_pulses", 64'(done_cnt), 64'd2);

        // T2: R1=5, R2=3, SUB R1,R2
        do_reset();
        rom[0] = 23'h110005; rom[1] = 23'h120003; rom[2] = 23'h312000; rom[3] = 23'h700000;
        launch(8);
        tick(6 + 2 * W);
        chk("t2_ex1", 64'({eo, ei}), 64'({10'h002, 10'h100}));
        tick(1);
        chk("t2_ex2", 64'({eo, ei, addsub}), 64'({10'h004, 10'h200, 1'b1}));
        tick(1);
        chk("t2_ex3", 64'({eo, ei, addsub, instr_done}), 64'({10'h100, 10'h002, 1'b1, 1'b1}));
        drain();
        chk("t2_r1", 64'(r[1]), 64'h2);

        // T3: JMP 0x1FF, NOP at 511 wraps to 0; then JMP 0x005
        do_reset();
        rom[0] = 23'h4001FF; rom[511] = 23'h600000;
        launch(3);
        tick(3 + W);
        chk("t3_addr_511", 64'(rom_addr), 64'h1FF);
        tick(2 + W);
        chk("t3_addr_wrap", 64'(rom_addr), 64'h0);
        drain();
        do_reset();
        rom[0] = 23'h400005; rom[5] = 23'h700000;
        launch(2);
        tick(3 + W);
        chk("t3_addr_5", 64'(rom_addr), 64'h5);
        drain();
        chk("t3_halted", 64'(halted), 64'd1);

        // T4: illegal opcode, then a fresh start clears the flag
        do_reset();
        rom[0] = 23'h500000; rom[1] = 23'h700000;
        launch(2);
        tick(2);
        chk("t4_illegal_set", 64'(illegal), 64'd1);
        tick(1 + W);
        chk("t4_pc_advance", 64'(rom_addr), 64'h1);
        drain();
        chk("t4_illegal_sticky", 64'(illegal), 64'd1);
        rom[0] = 23'h600000;
        launch(2);
        tick(1);
        chk("t4_illegal_cleared", 64'(illegal), 64'd0);
        drain();

        // T5: reset during EX2 of ADD, then restart from the reset vector
        do_reset();
        rom[0] = 23'h212000; rom[1] = 23'h700000;
        launch(2);
        tick(3);
        chk("t5_in_ex2", 64'({ei, addsub}), 64'({10'h200, 1'b0}));
        #2;
        q.delete();
        rst = 1'b0;
        last_ir = '0;
        #1 chk("t5_async_reset",
               64'({rom_addr, eo, ei, addsub, data, busy, halted, instr_done, illegal}), 64'd0);
        tick(2);
        rst = 1'b1;
        launch(2);
        tick(1);
        chk("t5_refetch_addr", 64'({rom_addr, busy}), 64'({9'd0, 1'b1}));
        drain();

`ifdef SEQ_STEP_EN
        // T6: single-step holds between instructions until step pulses
        do_reset();
        step = 1'b0;
        rom[0] = 23'h110007; rom[1] = 23'h120009; rom[2] = 23'h700000;
        launch(0);
        tick(2);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t6_wait", 64'({busy, eo, ei, rom_addr}), 64'({1'b1, 20'd0, 9'd1}));
        end
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        tick(2);
        chk("t6_second_mvi", 64'({eo, ei}), 64'({10'h200, 10'h004}));
        tick(3);
        chk("t6_wait2", 64'({busy, halted}), 64'({1'b1, 1'b0}));
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        tick(3);
        chk("t6_halted", 64'({halted, r[2]}), 64'({1'b1, 16'h0009}));
        step = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
